// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/memory status from the datapath in,
// enables, flushes and status back out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_rs1;
    logic [3:0]       id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [3:0]       ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             memwb_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath side: drives status, consumes control.
    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, state, mem_err, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ack,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, state, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline controller: memory-wait freeze with timeout, branch
// flush, load-use stall, and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic timeout_hit_s;
    logic mem_wait_s;
    logic load_use_s;
    logic pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s;
    logic ifid_flush_s, idex_flush_s;

    // Hazard detection; register 0 is hard-wired and never a real dependency.
    always_comb begin
        timeout_hit_s = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
        mem_wait_s    = bus.mem_req & ~bus.mem_ack & ~timeout_hit_s;
        load_use_s    = bus.ex_memread & (bus.ex_rd != 4'd0) &
                        ((bus.id_use1 & (bus.id_rs1 == bus.ex_rd)) |
                         (bus.id_use2 & (bus.id_rs2 == bus.ex_rd)));
    end

    // Enables/flushes: reset, then freeze, branch flush, load-use bubble, normal.
    always_comb begin
        pc_we_s      = 1'b1;
        ifid_we_s    = 1'b1;
        idex_we_s    = 1'b1;
        exmem_we_s   = 1'b1;
        memwb_we_s   = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        if (reset) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_we_s    = 1'b0;
            exmem_we_s   = 1'b0;
            memwb_we_s   = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (mem_wait_s) begin
            pc_we_s    = 1'b0;
            ifid_we_s  = 1'b0;
            idex_we_s  = 1'b0;
            exmem_we_s = 1'b0;
            memwb_we_s = 1'b0;
        end else if (bus.ex_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            ifid_flush_s = 1'b0;
        end
    end

    // Next state: RUN/MEM_WAIT transitions, wait timer, sticky error, stall counter.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_wait_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_wait_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    // Ack, dropped request, or forced release all resume the pipe.
                    state_d = RUN;
                    if (timeout_hit_s && bus.mem_req && !bus.mem_ack) begin
                        mem_err_d = 1'b1;
                    end else begin
                        mem_err_d = mem_err_q;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        if (!pc_we_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State register with synchronous reset taking precedence over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we      = pc_we_s;
    assign bus.ifid_we    = ifid_we_s;
    assign bus.idex_we    = idex_we_s;
    assign bus.exmem_we   = exmem_we_s;
    assign bus.memwb_we   = memwb_we_s;
    assign bus.ifid_flush = ifid_flush_s;
    assign bus.idex_flush = idex_flush_s;
    assign bus.state      = state_q;
    assign bus.mem_err    = mem_err_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance for hazards and memory
// wait, a TIMEOUT=4 / CNT_W=4 instance for timeout and saturation.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // control vector order: pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush
    localparam logic [6:0] C_NORM  = 7'b11111_00;
    localparam logic [6:0] C_FRZ   = 7'b00000_00;
    localparam logic [6:0] C_BR    = 7'b11111_11;
    localparam logic [6:0] C_LU    = 7'b00111_01;
    localparam logic [6:0] C_RST   = 7'b00000_11;

    pipe_ctrl_if #(.CNT_W(16)) a ();
    pipe_ctrl_if #(.CNT_W(4))  b ();

    pipe_ctrl #(.TIMEOUT(255), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(a));
    pipe_ctrl #(.TIMEOUT(4),   .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    logic [6:0] ctl0, ctl1;
    assign ctl0 = {a.pc_we, a.ifid_we, a.idex_we, a.exmem_we, a.memwb_we, a.ifid_flush, a.idex_flush};
    assign ctl1 = {b.pc_we, b.ifid_we, b.idex_we, b.exmem_we, b.memwb_we, b.ifid_flush, b.idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a.id_rs1 = 4'd0; a.id_rs2 = 4'd0; a.id_use1 = 1'b0; a.id_use2 = 1'b0;
        a.ex_rd = 4'd0; a.ex_memread = 1'b0; a.ex_branch_taken = 1'b0;
        a.mem_req = 1'b0; a.mem_ack = 1'b0;
    endtask

    task automatic idle_b();
        b.id_rs1 = 4'd0; b.id_rs2 = 4'd0; b.id_use1 = 1'b0; b.id_use2 = 1'b0;
        b.ex_rd = 4'd0; b.ex_memread = 1'b0; b.ex_branch_taken = 1'b0;
        b.mem_req = 1'b0; b.mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_a();
        idle_b();
        #1 chk("rst_ctl", 32'(ctl0), 32'(C_RST));
        tick(); tick();
        chk("rst_state", 32'(a.state), 32'd0);
        chk("rst_stall", 32'(a.stall_cnt), 32'd0);
        chk("rst_err", 32'(a.mem_err), 32'd0);

        reset = 1'b0;
        #1 chk("normal", 32'(ctl0), 32'(C_NORM));

        // load from r0 never stalls
        a.ex_memread = 1'b1; a.ex_rd = 4'd0; a.id_rs1 = 4'd0; a.id_use1 = 1'b1;
        #1 chk("r0_ctl", 32'(ctl0), 32'(C_NORM));
        tick();
        chk("r0_stall", 32'(a.stall_cnt), 32'd0);

        // load-use on rs1
        a.ex_rd = 4'd5; a.id_rs1 = 4'd5;
        #1 chk("lu1_ctl", 32'(ctl0), 32'(C_LU));
        tick();
        a.ex_memread = 1'b0;
        #1 chk("lu1_next", 32'(ctl0), 32'(C_NORM));
        chk("lu1_stall", 32'(a.stall_cnt), 32'd1);
        tick();

        // rs1 matches but is unused: no hazard; rs2 match used: hazard
        a.ex_memread = 1'b1; a.ex_rd = 4'd7; a.id_rs1 = 4'd7; a.id_use1 = 1'b0;
        a.id_rs2 = 4'd3; a.id_use2 = 1'b1;
        #1 chk("nouse_ctl", 32'(ctl0), 32'(C_NORM));
        a.id_rs2 = 4'd7;
        #1 chk("lu2_ctl", 32'(ctl0), 32'(C_LU));
        tick();
        chk("lu2_stall", 32'(a.stall_cnt), 32'd2);

        // branch together with load-use: branch wins, no stall
        a.ex_branch_taken = 1'b1;
        #1 chk("br_lu_ctl", 32'(ctl0), 32'(C_BR));
        tick();
        chk("br_lu_stall", 32'(a.stall_cnt), 32'd2);
        idle_a();

        // memory wait, ack arriving on the 4th cycle of the request
        a.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_frz%0d", i), 32'(ctl0), 32'(C_FRZ));
            tick();
            chk($sformatf("mw_state%0d", i), 32'(a.state), 32'd1);
        end
        a.mem_ack = 1'b1;
        #1 chk("mw_ack_ctl", 32'(ctl0), 32'(C_NORM));
        tick();
        chk("mw_ack_state", 32'(a.state), 32'd0);
        chk("mw_stall", 32'(a.stall_cnt), 32'd5);

        // ack in the same cycle as the request: no freeze
        #1 chk("same_ack_ctl", 32'(ctl0), 32'(C_NORM));
        tick();
        chk("same_ack_state", 32'(a.state), 32'd0);
        chk("same_ack_stall", 32'(a.stall_cnt), 32'd5);

        // dropping the request acts as ack; branch in that cycle is honoured
        a.mem_ack = 1'b0;
        tick();
        chk("drop_wait", 32'(a.state), 32'd1);
        a.mem_req = 1'b0; a.ex_branch_taken = 1'b1;
        #1 chk("drop_ctl", 32'(ctl0), 32'(C_BR));
        tick();
        chk("drop_state", 32'(a.state), 32'd0);
        chk("drop_stall", 32'(a.stall_cnt), 32'd6);
        idle_a();

        // dut1: timeout after 4 MEM_WAIT cycles
        b.mem_req = 1'b1;
        #1 chk("to_run_frz", 32'(ctl1), 32'(C_FRZ));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("to_state%0d", i), 32'(b.state), 32'd1);
            #1 chk($sformatf("to_frz%0d", i), 32'(ctl1), 32'(C_FRZ));
            tick();
        end
        chk("to_err_before", 32'(b.mem_err), 32'd0);
        #1 chk("to_release_ctl", 32'(ctl1), 32'(C_NORM));
        tick();
        chk("to_state_run", 32'(b.state), 32'd0);
        chk("to_err", 32'(b.mem_err), 32'd1);
        chk("to_stall", 32'(b.stall_cnt), 32'd4);

        // keep freezing: counter saturates at 15, error stays sticky
        repeat (40) tick();
        chk("sat_stall", 32'(b.stall_cnt), 32'd15);
        chk("err_sticky", 32'(b.mem_err), 32'd1);
        repeat (5) tick();
        chk("sat_hold", 32'(b.stall_cnt), 32'd15);

        // reset while dut0 sits in MEM_WAIT
        a.mem_req = 1'b1;
        tick();
        chk("rw_wait", 32'(a.state), 32'd1);
        reset = 1'b1;
        #1 chk("rw_ctl", 32'(ctl0), 32'(C_RST));
        tick();
        chk("rw_state", 32'(a.state), 32'd0);
        chk("rw_stall", 32'(a.stall_cnt), 32'd0);
        chk("rw_err", 32'(a.mem_err), 32'd0);
        chk("rw_err_b", 32'(b.mem_err), 32'd0);
        chk("rw_stall_b", 32'(b.stall_cnt), 32'd0);
        reset = 1'b0;
        idle_a();
        idle_b();
        #1 chk("post_rst_ctl", 32'(ctl0), 32'(C_NORM));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
